data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- MEM-stage block that sits directly downstream of the EX/MEM pipeline register and replaces the direct MEM_WB hand-off.
- Performs byte and word loads and stores into an internal big-endian byte-addressed data memory that has a configurable wait-state latency.
- Asserts a stall back to the pipeline while an access is in flight.
- Registers the writeback result (load data or ALU result) toward the WB stage.

Parameters:
ADDR_W, 8, memory address width in bits; MEM_BYTES = 2**ADDR_W.
WAIT_CYCLES, 2, extra cycles per memory access; legal range 0..15.

Ports:
Clk  input  1  clock; all state updates on posedge.
Reset  input  1  asynchronous, active-high reset.
MEM_load_store_instr  input  1  memory access request valid for this cycle.
MEM_store  input  1  1 = store, 0 = load; qualified by MEM_load_store_instr.
MEM_size  input  1  1 = word (32 bits), 0 = byte.
MEM_address  input  32  byte address; only [ADDR_W-1:0] used (modulo MEM_BYTES).
MEM_store_data  input  32  store data; byte stores use [7:0].
MEM_alu_result  input  32  writeback value for non-memory instructions.
MEM_RF_enable  input  1  instruction writes the register file.
MEM_rd  input  4  destination register.
mem_stall  output  1  combinational; high while an access is incomplete.
WB_RF_enable  output  1  registered writeback enable.
WB_rd  output  4  registered destination register.
WB_data  output  32  registered writeback data.
misalign_fault  output  1  registered one-cycle pulse on a misaligned word access.

Behaviour:
- Reset (async, any time): state=IDLE, cnt=0, WB_RF_enable=0, WB_rd=0, WB_data=0, misalign_fault=0. Memory contents are not cleared.
- Reset mid-access: aborts the access; no memory write, no writeback.
- Byte order is big-endian. A word at address A is {mem[A], mem[A+1], mem[A+2], mem[A+3]}.
- Byte load returns {24'b0, mem[A]} (zero-extended).
- Byte store writes mem[A] = MEM_store_data[7:0].
- FSM states: IDLE, BUSY.
- IDLE, no request: each edge, WB_RF_enable <= MEM_RF_enable, WB_rd <= MEM_rd, WB_data <= MEM_alu_result, misalign_fault <= 0.
- IDLE, request with MEM_size=1 and MEM_address[1:0] != 0:
  - misalign_fault <= 1 for one cycle.
  - No memory access; WB_RF_enable <= 0.
  - mem_stall stays 0; state stays IDLE.
- IDLE, valid request, WAIT_CYCLES=0: completes at the next edge with no stall.
  - Store: memory written; WB_RF_enable <= 0.
  - Load: WB_data <= load data; WB_rd <= MEM_rd; WB_RF_enable <= MEM_RF_enable.
- IDLE, valid request, WAIT_CYCLES>0:
  - mem_stall=1 combinationally in the same cycle.
  - At the next edge: state <= BUSY, cnt <= 1, WB_RF_enable <= 0 (bubble).
- BUSY, cnt < WAIT_CYCLES: mem_stall=1; at the edge cnt <= cnt+1 and WB_RF_enable <= 0.
- BUSY, cnt == WAIT_CYCLES: mem_stall=0; at the edge the access completes as in the WAIT_CYCLES=0 case, then state <= IDLE and cnt <= 0.
- Access timing: WAIT_CYCLES+1 cycles per access, with the stall high for WAIT_CYCLES cycles.
- Pipeline contract: EX/MEM inputs are held stable while mem_stall=1.
- Flush: MEM_load_store_instr dropping to 0 while in BUSY aborts the access. No write, WB_RF_enable <= 0, state <= IDLE.
- Back-to-back requests: a new request is accepted in the IDLE cycle right after completion.
- Address wrap: addresses at or above MEM_BYTES wrap modulo MEM_BYTES.
  - Word at A = MEM_BYTES-4 is legal.
  - Aligned words never straddle the top of memory.
- mem_stall is never asserted when there is no request.

Test Plan:
- Reset asserted while Clk is idle -> all outputs 0 immediately (async); mem_stall=0.
- WAIT_CYCLES=2: word store 0xDEADBEEF @0x10, then word load @0x10 with rd=3.
  - Each access shows mem_stall high for 2 cycles.
  - WB_data=0xDEADBEEF, WB_rd=3, WB_RF_enable=1 for one cycle after the load completes.
- Byte store 0xA5 @0x11, then word load @0x10 -> 0xDEA5BEEF. Byte load @0x11 -> 0x000000A5.
- Word load @0x12 -> misalign_fault pulses 1 cycle, mem_stall=0, WB_RF_enable=0, memory unchanged.
- Reset pulsed during BUSY of a word store 0x12345678 @0x20 -> subsequent load @0x20 returns the prior contents; FSM in IDLE after reset.
- WAIT_CYCLES=0 build: ALU op (rd=1, 0x5) then load then ALU op (rd=2, 0x7) back-to-back -> no stall; three consecutive WB writes in order. Address 0x1FC with ADDR_W=8 accesses 0xFC.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// MEM-stage load/store unit with a big-endian byte-addressed data memory,
// configurable wait states, a pipeline stall and a registered writeback stage.
module data_mem_access_unit #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MEM_load_store_instr,
    input  logic        MEM_store,
    input  logic        MEM_size,
    input  logic [31:0] MEM_address,
    input  logic [31:0] MEM_store_data,
    input  logic [31:0] MEM_alu_result,
    input  logic        MEM_RF_enable,
    input  logic [3:0]  MEM_rd,
    output logic        mem_stall,
    output logic        WB_RF_enable,
    output logic [3:0]  WB_rd,
    output logic [31:0] WB_data,
    output logic        misalign_fault
);
    localparam int         MEM_BYTES = 2 ** ADDR_W;
    localparam logic [3:0] WAIT_C    = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [7:0]        mem [MEM_BYTES];

    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic              misaligned;
    logic              req_ok;
    logic              complete;
    logic              do_write;
    logic [31:0]       load_data;
    logic              unused_addr;

    // Address bits above the memory size are ignored, giving modulo wrap.
    assign a0          = MEM_address[ADDR_W-1:0];
    assign a1          = a0 + ADDR_W'(1);
    assign a2          = a0 + ADDR_W'(2);
    assign a3          = a0 + ADDR_W'(3);
    assign unused_addr = ^MEM_address[31:ADDR_W];

    assign misaligned = MEM_load_store_instr && MEM_size && (MEM_address[1:0] != 2'b00);
    assign req_ok     = MEM_load_store_instr && !misaligned;
    assign complete   = req_ok && ((state == IDLE && WAIT_C == 4'd0) ||
                                   (state == BUSY && cnt == WAIT_C));
    assign mem_stall  = req_ok && ((state == IDLE && WAIT_C != 4'd0) ||
                                   (state == BUSY && cnt != WAIT_C));
    assign do_write   = complete && MEM_store;
    assign load_data  = MEM_size ? {mem[a0], mem[a1], mem[a2], mem[a3]}
                                 : {24'h0, mem[a0]};

    // Control and writeback registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            WB_RF_enable   <= 1'b0;
            WB_rd          <= 4'd0;
            WB_data        <= 32'h0;
            misalign_fault <= 1'b0;
        end else begin
            misalign_fault <= 1'b0;
            if (!MEM_load_store_instr) begin
                // Dropping the request while BUSY is a flush: emit a bubble.
                if (state == BUSY) begin
                    WB_RF_enable <= 1'b0;
                end else begin
                    WB_RF_enable <= MEM_RF_enable;
                    WB_rd        <= MEM_rd;
                    WB_data      <= MEM_alu_result;
                end
                state <= IDLE;
                cnt   <= 4'd0;
            end else if (misaligned) begin
                misalign_fault <= 1'b1;
                WB_RF_enable   <= 1'b0;
                state          <= IDLE;
                cnt            <= 4'd0;
            end else if (complete) begin
                if (MEM_store) begin
                    WB_RF_enable <= 1'b0;
                end else begin
                    WB_RF_enable <= MEM_RF_enable;
                    WB_rd        <= MEM_rd;
                    WB_data      <= load_data;
                end
                state <= IDLE;
                cnt   <= 4'd0;
            end else begin
                state        <= BUSY;
                cnt          <= cnt + 4'd1;
                WB_RF_enable <= 1'b0;
            end
        end
    end

    // Memory array: written only on the completing cycle of a store
    always_ff @(posedge Clk) begin
        if (do_write && !Reset) begin
            if (MEM_size) begin
                mem[a0] <= MEM_store_data[31:24];
                mem[a1] <= MEM_store_data[23:16];
                mem[a2] <= MEM_store_data[15:8];
                mem[a3] <= MEM_store_data[7:0];
            end else begin
                mem[a0] <= MEM_store_data[7:0];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Bench for data_mem_access_unit: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0
// instance share stimulus; a scoreboard queue holds expected writebacks.
module tb_data_mem_access_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        req = 1'b0, st = 1'b0, sz = 1'b0, rfe = 1'b0;
    logic [31:0] addr = '0, sdata = '0, alu = '0;
    logic [3:0]  rd = '0;

    logic        stall2, rfen2, fault2, stall0, rfen0, fault0;
    logic [3:0]  rd2, rd0;
    logic [31:0] data2, data0;

    typedef struct packed {
        logic        en;
        logic [3:0]  rd;
        logic [31:0] data;
    } wb_t;

    wb_t        exp_q[$];
    logic [7:0] model [256];
    int         passed = 0;
    int         total = 0;

    always #5 Clk = ~Clk;

    data_mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MEM_load_store_instr(req), .MEM_store(st),
        .MEM_size(sz), .MEM_address(addr), .MEM_store_data(sdata),
        .MEM_alu_result(alu), .MEM_RF_enable(rfe), .MEM_rd(rd),
        .mem_stall(stall2), .WB_RF_enable(rfen2), .WB_rd(rd2), .WB_data(data2),
        .misalign_fault(fault2)
    );

    data_mem_access_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .MEM_load_store_instr(req), .MEM_store(st),
        .MEM_size(sz), .MEM_address(addr), .MEM_store_data(sdata),
        .MEM_alu_result(alu), .MEM_RF_enable(rfe), .MEM_rd(rd),
        .mem_stall(stall0), .WB_RF_enable(rfen0), .WB_rd(rd0), .WB_data(data0),
        .misalign_fault(fault0)
    );

    // Full access on the WAIT_CYCLES=2 instance, starting just after a posedge.
    task automatic access2(input logic ist, input logic isz, input logic [31:0] iaddr,
                           input logic [31:0] isd, input logic [3:0] ird, input string name);
        wb_t        e;
        int         stalls;
        logic [7:0] a;
        a = iaddr[7:0];
        e.en = !ist;
        e.rd = ird;
        if (isz) e.data = {model[a], model[a+8'd1], model[a+8'd2], model[a+8'd3]};
        else     e.data = {24'h0, model[a]};
        exp_q.push_back(e);
        if (ist) begin
            if (isz) begin
                model[a] = isd[31:24]; model[a+8'd1] = isd[23:16];
                model[a+8'd2] = isd[15:8]; model[a+8'd3] = isd[7:0];
            end else begin
                model[a] = isd[7:0];
            end
        end
        req = 1'b1; st = ist; sz = isz; addr = iaddr; sdata = isd; rd = ird;
        rfe = !ist; alu = 32'h0BAD0BAD;
        #1;
        stalls = 0;
        while (stall2 === 1'b1 && stalls < 20) begin
            stalls++;
            @(posedge Clk); #1;
        end
        total++; if (stalls != 2) $display("FAIL %s_stall_cycles got %0d exp 2", name, stalls); else passed++;
        total++; if (rfen2 !== 1'b0) $display("FAIL %s_bubble got %b exp 0", name, rfen2); else passed++;
        @(posedge Clk); #1;
        e = exp_q.pop_front();
        req = 1'b0; rfe = 1'b0;
        total++; if (rfen2 !== e.en) $display("FAIL %s_wb_en got %b exp %b", name, rfen2, e.en); else passed++;
        if (e.en) begin
            total++; if (rd2 !== e.rd) $display("FAIL %s_wb_rd got %0d exp %0d", name, rd2, e.rd); else passed++;
            total++; if (data2 !== e.data) $display("FAIL %s_wb_data got %h exp %h", name, data2, e.data); else passed++;
        end
        @(posedge Clk); #1;
        total++; if (rfen2 !== 1'b0) $display("FAIL %s_wb_en_pulse got %b exp 0", name, rfen2); else passed++;
    endtask

    task automatic test_reset();
        #2 Reset = 1'b1;
        #1;
        total++; if (rfen2 !== 1'b0) $display("FAIL reset_wb_en got %b exp 0", rfen2); else passed++;
        total++; if (rd2 !== 4'd0) $display("FAIL reset_wb_rd got %0d exp 0", rd2); else passed++;
        total++; if (data2 !== 32'h0) $display("FAIL reset_wb_data got %h exp 0", data2); else passed++;
        total++; if (fault2 !== 1'b0) $display("FAIL reset_fault got %b exp 0", fault2); else passed++;
        total++; if (stall2 !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall2); else passed++;
        total++; if ({rfen0, rd0, data0, fault0, stall0} !== 38'h0) $display("FAIL reset_dut0 got %h exp 0", {rfen0, rd0, data0, fault0, stall0}); else passed++;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
    endtask

    task automatic test_word();
        access2(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'd0, "st_word");
        access2(1'b0, 1'b1, 32'h10, 32'h0, 4'd3, "ld_word");
    endtask

    task automatic test_byte();
        access2(1'b1, 1'b0, 32'h11, 32'h000000A5, 4'd0, "st_byte");
        access2(1'b0, 1'b1, 32'h10, 32'h0, 4'd5, "ld_word_after_byte");
        access2(1'b0, 1'b0, 32'h11, 32'h0, 4'd6, "ld_byte");
    endtask

    task automatic test_misalign();
        req = 1'b1; st = 1'b1; sz = 1'b1; addr = 32'h12; sdata = 32'h11111111;
        rfe = 1'b1; rd = 4'd9;
        #1;
        total++; if (stall2 !== 1'b0) $display("FAIL misalign_stall got %b exp 0", stall2); else passed++;
        @(posedge Clk); #1;
        total++; if (fault2 !== 1'b1) $display("FAIL misalign_fault got %b exp 1", fault2); else passed++;
        total++; if (rfen2 !== 1'b0) $display("FAIL misalign_wb_en got %b exp 0", rfen2); else passed++;
        req = 1'b0; rfe = 1'b0;
        @(posedge Clk); #1;
        total++; if (fault2 !== 1'b0) $display("FAIL misalign_pulse got %b exp 0", fault2); else passed++;
        access2(1'b0, 1'b1, 32'h10, 32'h0, 4'd7, "ld_after_misalign");
    endtask

    task automatic test_reset_mid_access();
        access2(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4'd0, "st_prior");
        req = 1'b1; st = 1'b1; sz = 1'b1; addr = 32'h20; sdata = 32'h12345678;
        rfe = 1'b0;
        @(posedge Clk); #1;
        total++; if (stall2 !== 1'b1) $display("FAIL midrst_busy_stall got %b exp 1", stall2); else passed++;
        req = 1'b0;
        Reset = 1'b1;
        #1;
        total++; if (stall2 !== 1'b0) $display("FAIL midrst_stall got %b exp 0", stall2); else passed++;
        total++; if (rfen2 !== 1'b0) $display("FAIL midrst_wb_en got %b exp 0", rfen2); else passed++;
        @(posedge Clk); #1;
        Reset = 1'b0;
        access2(1'b0, 1'b1, 32'h20, 32'h0, 4'd7, "ld_after_reset");
    endtask

    task automatic test_flush();
        req = 1'b1; st = 1'b0; sz = 1'b1; addr = 32'h10; rfe = 1'b1; rd = 4'd8;
        #1;
        total++; if (stall2 !== 1'b1) $display("FAIL flush_stall_start got %b exp 1", stall2); else passed++;
        @(posedge Clk); #1;
        req = 1'b0; rfe = 1'b0;
        #1;
        total++; if (stall2 !== 1'b0) $display("FAIL flush_stall_drop got %b exp 0", stall2); else passed++;
        @(posedge Clk); #1;
        total++; if (rfen2 !== 1'b0) $display("FAIL flush_wb_en got %b exp 0", rfen2); else passed++;
        access2(1'b0, 1'b0, 32'h13, 32'h0, 4'd10, "ld_after_flush");
    endtask

    task automatic test_back_to_back();
        logic        t_req [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] t_alu [3] = '{32'h5, 32'h99, 32'h7};
        logic [3:0]  t_rd  [3] = '{4'd1, 4'd4, 4'd2};
        wb_t         e;
        req = 1'b1; st = 1'b1; sz = 1'b1; addr = 32'hFC; sdata = 32'hCAFEBABE; rfe = 1'b0;
        #1;
        total++; if (stall0 !== 1'b0) $display("FAIL b2b_store_stall got %b exp 0", stall0); else passed++;
        @(posedge Clk); #1;
        total++; if (rfen0 !== 1'b0) $display("FAIL b2b_store_wb_en got %b exp 0", rfen0); else passed++;
        for (int i = 0; i < 3; i++) begin
            e.en = 1'b1;
            e.rd = t_rd[i];
            e.data = t_req[i] ? 32'hCAFEBABE : t_alu[i];
            exp_q.push_back(e);
            req = t_req[i]; st = 1'b0; sz = 1'b1; addr = 32'h1FC; rfe = 1'b1;
            rd = t_rd[i]; alu = t_alu[i];
            #1;
            total++; if (stall0 !== 1'b0) $display("FAIL b2b_stall_%0d got %b exp 0", i, stall0); else passed++;
            @(posedge Clk); #1;
            e = exp_q.pop_front();
            total++; if (rfen0 !== e.en) $display("FAIL b2b_wb_en_%0d got %b exp %b", i, rfen0, e.en); else passed++;
            total++; if (rd0 !== e.rd) $display("FAIL b2b_wb_rd_%0d got %0d exp %0d", i, rd0, e.rd); else passed++;
            total++; if (data0 !== e.data) $display("FAIL b2b_wb_data_%0d got %h exp %h", i, data0, e.data); else passed++;
        end
        req = 1'b0; rfe = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_misalign();
        test_reset_mid_access();
        test_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
